// File: rtl/wb_stage_pkg.sv
// Shared writeback-stage types: word/register widths, load-kind codes and the W register layout.
// Consumed by wb_stage and load_ext via import wb_stage_pkg::*.
package wb_stage_pkg;

    localparam int WORD        = 32;
    localparam int TYPE_REG    = 5;
    localparam int TYPE_LDTYPE = 3;

    localparam logic [TYPE_LDTYPE-1:0] LD_NONE = 3'd0;
    localparam logic [TYPE_LDTYPE-1:0] LD_W    = 3'd1;
    localparam logic [TYPE_LDTYPE-1:0] LD_B    = 3'd2;
    localparam logic [TYPE_LDTYPE-1:0] LD_BU   = 3'd3;
    localparam logic [TYPE_LDTYPE-1:0] LD_H    = 3'd4;
    localparam logic [TYPE_LDTYPE-1:0] LD_HU   = 3'd5;

    typedef struct packed {
        logic                   valid;
        logic [WORD-1:0]        pc;
        logic                   wen;
        logic [TYPE_REG-1:0]    waddr;
        logic [TYPE_LDTYPE-1:0] ldtype;
        logic [WORD-1:0]        alu;
        logic [WORD-1:0]        rdata;
        logic [1:0]             offset;
    } wreg_t;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Combinational load extension and alignment check for the writeback stage.
// Sub-word loads are supported only when WB_SUBWORD_EN is defined; otherwise they act as LD_W.
module load_ext
    import wb_stage_pkg::*;
(
    input  logic [TYPE_LDTYPE-1:0] ldtype_i,
    input  logic [WORD-1:0]        rdata_i,
    input  logic [1:0]             offset_i,
    input  logic [WORD-1:0]        alu_i,
    output logic [WORD-1:0]        data_o,
    output logic                   misalign_o
);

`ifdef WB_SUBWORD_EN
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    assign byteSel = rdata_i[8*offset_i +: 8];
    assign halfSel = rdata_i[16*offset_i[1] +: 16];

    always_comb begin
        data_o     = alu_i;
        misalign_o = 1'b0;
        case (ldtype_i)
            LD_W: begin
                data_o     = rdata_i;
                misalign_o = (offset_i != 2'd0);
            end
            LD_B:  data_o = {{24{byteSel[7]}}, byteSel};
            LD_BU: data_o = {24'd0, byteSel};
            LD_H: begin
                data_o     = {{16{halfSel[15]}}, halfSel};
                misalign_o = offset_i[0];
            end
            LD_HU: begin
                data_o     = {16'd0, halfSel};
                misalign_o = offset_i[0];
            end
            default: ;
        endcase
    end
`else
    always_comb begin
        data_o     = alu_i;
        misalign_o = 1'b0;
        case (ldtype_i)
            LD_W, LD_B, LD_BU, LD_H, LD_HU: begin
                data_o     = rdata_i;
                misalign_o = (offset_i != 2'd0);
            end
            default: ;
        endcase
    end
`endif

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers the memory-stage result for one cycle and drives the GRF write port.
// Sub-word load support is selected by the WB_SUBWORD_EN macro inside load_ext.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_PC = 32'h0000_3000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   m_valid,
    input  logic [WORD-1:0]        m_pc,
    input  logic                   m_wen,
    input  logic [TYPE_REG-1:0]    m_waddr,
    input  logic [WORD-1:0]        m_alu,
    input  logic [TYPE_LDTYPE-1:0] m_ldtype,
    input  logic [WORD-1:0]        m_rdata,
    input  logic [1:0]             m_offset,
    input  logic                   m_stall,
    input  logic                   flush,
    output logic                   w_en,
    output logic [WORD-1:0]        w_pc,
    output logic                   w_wen,
    output logic [TYPE_REG-1:0]    w_waddr,
    output logic [WORD-1:0]        w_wdata,
    output logic                   w_misalign,
    output logic [WORD-1:0]        retired
);

    wreg_t           w_q, w_d;
    wreg_t           bubble;
    logic [WORD-1:0] retired_q, retired_d;
    logic [WORD-1:0] extData;
    logic            extMisalign;

    always_comb begin
        bubble    = '0;
        bubble.pc = RESET_PC;
    end

    always_comb begin
        w_d = bubble;
        if (!(m_stall || flush)) begin
            w_d = '{valid:  m_valid,  pc:     m_pc,
                    wen:    m_wen,    waddr:  m_waddr,
                    ldtype: m_ldtype, alu:    m_alu,
                    rdata:  m_rdata,  offset: m_offset};
        end
    end

    assign retired_d = retired_q + {{(WORD-1){1'b0}}, w_q.valid};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_q       <= bubble;
            retired_q <= '0;
        end else begin
            w_q       <= w_d;
            retired_q <= retired_d;
        end
    end

    load_ext u_load_ext (
        .ldtype_i   (w_q.ldtype),
        .rdata_i    (w_q.rdata),
        .offset_i   (w_q.offset),
        .alu_i      (w_q.alu),
        .data_o     (extData),
        .misalign_o (extMisalign)
    );

    // A zero write tag doubles as "nothing pending" for the bypass and forwarding logic.
    assign w_en       = w_q.valid;
    assign w_pc       = w_q.pc;
    assign w_misalign = w_q.valid & extMisalign;
    assign w_wen      = w_q.valid & w_q.wen & ~w_misalign & (w_q.waddr != '0);
    assign w_waddr    = w_wen ? w_q.waddr : '0;
    assign w_wdata    = extData;
    assign retired    = retired_q;

endmodule
